// File: rtl/mux_32_8_pkg.sv
// Shared constants, debug types and byte-selection helpers for the 32->8 transmit mux.
// The IDLE_BYTE default here is the same one the 8->32 demux uses on the receive side.
package mux_32_8_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int CNT_W          = 2;

  localparam logic [BYTE_W-1:0] IDLE_BYTE_DEFAULT = 8'h00;

  // What the sequencer did on the most recent edge; exposed for checkers.
  typedef enum logic [1:0] {
    EV_IDLE      = 2'd0,
    EV_CONT      = 2'd1,
    EV_FROM_HOLD = 2'd2,
    EV_BYPASS    = 2'd3
  } mux_event_e;

  typedef struct packed {
    mux_event_e       last_event;
    logic [CNT_W-1:0] cnt;
    logic             hold_full;
  } mux_dbg_t;

  // Byte that goes out next from a word, given the configured order.
  function automatic logic [BYTE_W-1:0] head_byte(input logic [WORD_W-1:0] w,
                                                  input bit msb_first);
    return msb_first ? w[WORD_W-1 -: BYTE_W] : w[BYTE_W-1:0];
  endfunction

  // Word with its head byte consumed, so the following byte becomes the head.
  function automatic logic [WORD_W-1:0] advance_word(input logic [WORD_W-1:0] w,
                                                     input bit msb_first);
    return msb_first ? {w[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}}
                     : {{BYTE_W{1'b0}}, w[WORD_W-1:BYTE_W]};
  endfunction

endpackage

// File: rtl/mux_32_8_if.sv
// Word-in / byte-out bus of the 32->8 transmit mux.
// Handshake: a word moves when valid_in_32 && ready_out_32 at a rising clk_4f edge; ready
// never depends on valid combinationally, and the source holds data/valid until accepted.
interface mux_32_8_if;
  import mux_32_8_pkg::*;

  logic [WORD_W-1:0] data_in_32;
  logic              valid_in_32;
  logic              ready_out_32;
  logic [BYTE_W-1:0] data_mux_32_8;
  logic              valid_mux_32_8;
  logic              sop_mux_32_8;

  // master: word source plus byte sink; slave: the mux itself.
  modport master (
    output data_in_32, valid_in_32,
    input  ready_out_32, data_mux_32_8, valid_mux_32_8, sop_mux_32_8
  );

  modport slave (
    input  data_in_32, valid_in_32,
    output ready_out_32, data_mux_32_8, valid_mux_32_8, sop_mux_32_8
  );

endinterface

// File: rtl/mux_32_8_skid.sv
// One-word skid buffer: parks a word accepted while another is still being serialised.
// Ready is derived only from hold_full so the upstream handshake has no combinational path.
module mux_32_8_skid
  import mux_32_8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_push,
  input  logic              i_pop,
  output logic [WORD_W-1:0] o_hold_word,
  output logic              o_hold_full,
  output logic              o_ready
);

  logic [WORD_W-1:0] r_hold;
  logic              r_hold_full;
  logic              w_push_ok;

  // A push can only arrive while ready, which also keeps push and pop exclusive.
  assign w_push_ok = i_push && !r_hold_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_push_ok) begin
      r_hold      <= i_word;
      r_hold_full <= 1'b1;
    end else if (i_pop) begin
      r_hold_full <= 1'b0;
    end
  end

  assign o_hold_word = r_hold;
  assign o_hold_full = r_hold_full;
  assign o_ready     = !r_hold_full;

endmodule

// File: rtl/mux_32_8.sv
// 32->8 transmit mux: serialises each accepted word into four consecutive bytes on clk_4f,
// with a one-word skid so back-to-back words stream with no idle byte between them.
module mux_32_8
  import mux_32_8_pkg::*;
#(
  parameter bit                MSB_FIRST = 1'b1,
  parameter logic [BYTE_W-1:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
)(
  input  logic           clk_4f,
  input  logic           reset,
  mux_32_8_if.slave      bus,
  output mux_dbg_t       o_dbg
);

  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_shift;
  logic [BYTE_W-1:0] r_data;
  logic              r_valid;
  logic              r_sop;
  mux_event_e        r_event;

  logic              w_ready;
  logic              w_xfer;
  logic              w_busy;
  logic              w_push;
  logic              w_pop;
  logic [WORD_W-1:0] w_hold_word;
  logic              w_hold_full;

  assign w_busy = (r_cnt != '0);
  assign w_xfer = bus.valid_in_32 && w_ready;
  // Words arriving mid-word (including the wrap edge) park in hold; hold drains when idle.
  assign w_push = w_xfer && w_busy;
  assign w_pop  = !w_busy && w_hold_full;

  mux_32_8_skid u_skid (
    .clk         (clk_4f),
    .rst         (reset),
    .i_word      (bus.data_in_32),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .o_hold_word (w_hold_word),
    .o_hold_full (w_hold_full),
    .o_ready     (w_ready)
  );

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= IDLE_BYTE;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_event <= EV_IDLE;
    end else if (w_busy) begin
      r_data  <= head_byte(r_shift, MSB_FIRST);
      r_shift <= advance_word(r_shift, MSB_FIRST);
      r_cnt   <= r_cnt + 2'd1;
      r_valid <= 1'b1;
      r_sop   <= 1'b0;
      r_event <= EV_CONT;
    end else if (w_hold_full) begin
      r_data  <= head_byte(w_hold_word, MSB_FIRST);
      r_shift <= advance_word(w_hold_word, MSB_FIRST);
      r_cnt   <= 2'd1;
      r_valid <= 1'b1;
      r_sop   <= 1'b1;
      r_event <= EV_FROM_HOLD;
    end else if (w_xfer) begin
      r_data  <= head_byte(bus.data_in_32, MSB_FIRST);
      r_shift <= advance_word(bus.data_in_32, MSB_FIRST);
      r_cnt   <= 2'd1;
      r_valid <= 1'b1;
      r_sop   <= 1'b1;
      r_event <= EV_BYPASS;
    end else begin
      r_data  <= IDLE_BYTE;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_event <= EV_IDLE;
    end
  end

  assign bus.ready_out_32   = w_ready;
  assign bus.data_mux_32_8  = r_data;
  assign bus.valid_mux_32_8 = r_valid;
  assign bus.sop_mux_32_8   = r_sop;

  assign o_dbg.last_event = r_event;
  assign o_dbg.cnt        = r_cnt;
  assign o_dbg.hold_full  = w_hold_full;

endmodule

// File: tb/tb_mux_32_8.sv
// Bench for mux_32_8: expected {sop, byte} pairs are queued when a word is accepted and
// popped each cycle the DUT produces output; an idle cycle is expected when the queue is empty.
module tb_mux_32_8;
  import mux_32_8_pkg::*;

  logic clk_4f = 1'b0;
  logic reset  = 1'b1;

  mux_32_8_if bus();
  mux_32_8_if bus_lsb();
  mux_dbg_t   dbg;
  mux_dbg_t   dbg_lsb;

  mux_32_8 #(.MSB_FIRST(1'b1), .IDLE_BYTE(8'h00)) dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus),
    .o_dbg  (dbg)
  );

  mux_32_8 #(.MSB_FIRST(1'b0), .IDLE_BYTE(8'h00)) dut_lsb (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus_lsb),
    .o_dbg  (dbg_lsb)
  );

  always #5 clk_4f = ~clk_4f;

  logic [8:0]  exp_q[$];
  logic [31:0] word_q[$];
  int n_pass  = 0;
  int n_total = 0;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [31:0] d);
    @(negedge clk_4f);
    bus.valid_in_32 = v;
    bus.data_in_32  = d;
    #1;
  endtask

  task automatic drive_lsb(input logic v, input logic [31:0] d);
    @(negedge clk_4f);
    bus_lsb.valid_in_32 = v;
    bus_lsb.data_in_32  = d;
    #1;
  endtask

  task automatic push_msb(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), w[31 - 8*i -: 8]});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_4f); #1;
      n_total++;
      if ({bus.valid_mux_32_8, bus.sop_mux_32_8, bus.data_mux_32_8, bus.ready_out_32} !== {1'b0, 1'b0, 8'h00, 1'b1})
        $display("FAIL reset_hold: got v=%b s=%b d=%h r=%b want v=0 s=0 d=00 r=1",
                 bus.valid_mux_32_8, bus.sop_mux_32_8, bus.data_mux_32_8, bus.ready_out_32);
      else n_pass++;
    end
    n_total++;
    if (dbg !== '0) $display("FAIL reset_state: got dbg=%h want 0", dbg);
    else n_pass++;
    @(negedge clk_4f);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 32'h0);
      n_total++;
      if (bus.ready_out_32 !== 1'b1) $display("FAIL idle_ready: cycle %0d got %b want 1", c, bus.ready_out_32);
      else n_pass++;
      @(posedge clk_4f); #1;
      n_total++;
      if ({bus.valid_mux_32_8, bus.sop_mux_32_8, bus.data_mux_32_8} !== {2'b00, 8'h00})
        $display("FAIL idle_out: cycle %0d got v=%b s=%b d=%h want v=0 s=0 d=00",
                 c, bus.valid_mux_32_8, bus.sop_mux_32_8, bus.data_mux_32_8);
      else n_pass++;
    end
  endtask

  task automatic test_single;
    logic [9:0] exp_out;
    logic       v;
    for (int c = 0; c < 7; c++) begin
      v = (c == 0);
      drive(v, v ? 32'hA1B2C3D4 : 32'h0);
      n_total++;
      if (bus.ready_out_32 !== (exp_q.size() < 4)) $display("FAIL single_ready: cycle %0d got %b", c, bus.ready_out_32);
      else n_pass++;
      if (v && bus.ready_out_32) push_msb(32'hA1B2C3D4);
      @(posedge clk_4f); #1;
      if (exp_q.size() != 0) exp_out = {1'b1, exp_q.pop_front()};
      else exp_out = {2'b00, 8'h00};
      n_total++;
      if ({bus.valid_mux_32_8, bus.sop_mux_32_8, bus.data_mux_32_8} !== exp_out)
        $display("FAIL single_out: cycle %0d got %b_%b_%h want %b_%b_%h", c, bus.valid_mux_32_8,
                 bus.sop_mux_32_8, bus.data_mux_32_8, exp_out[9], exp_out[8], exp_out[7:0]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] words [3];
    logic [9:0]  exp_out;
    logic        v;
    int          idx = 0;
    int          low_cycles = 0;
    words[0] = 32'h01020304; words[1] = 32'h05060708; words[2] = 32'h090A0B0C;
    for (int c = 0; c < 40 && (idx < 3 || exp_q.size() != 0); c++) begin
      v = (idx < 3);
      drive(v, v ? words[idx] : 32'h0);
      n_total++;
      if (bus.ready_out_32 !== (exp_q.size() < 4))
        $display("FAIL b2b_ready: cycle %0d got %b want %b", c, bus.ready_out_32, (exp_q.size() < 4));
      else n_pass++;
      if (!bus.ready_out_32) low_cycles++;
      if (v && bus.ready_out_32) begin
        push_msb(words[idx]);
        idx++;
      end
      @(posedge clk_4f); #1;
      if (exp_q.size() != 0) exp_out = {1'b1, exp_q.pop_front()};
      else exp_out = {2'b00, 8'h00};
      n_total++;
      if ({bus.valid_mux_32_8, bus.sop_mux_32_8, bus.data_mux_32_8} !== exp_out)
        $display("FAIL b2b_out: cycle %0d got %b_%b_%h want %b_%b_%h", c, bus.valid_mux_32_8,
                 bus.sop_mux_32_8, bus.data_mux_32_8, exp_out[9], exp_out[8], exp_out[7:0]);
      else n_pass++;
    end
    n_total++;
    if (idx != 3 || exp_q.size() != 0) $display("FAIL b2b_done: words sent %0d want 3, bytes left %0d want 0", idx, exp_q.size());
    else n_pass++;
    n_total++;
    if (low_cycles != 6) $display("FAIL b2b_backpressure: ready low %0d cycles want 6", low_cycles);
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_source_stall;
    logic [9:0]  exp_out;
    logic [31:0] w;
    logic        v;
    for (int c = 0; c < 18; c++) begin
      v = ((c % 6) == 0);
      w = $urandom;
      drive(v, w);
      n_total++;
      if (bus.ready_out_32 !== 1'b1) $display("FAIL stall_ready: cycle %0d got %b want 1", c, bus.ready_out_32);
      else n_pass++;
      if (v && bus.ready_out_32) push_msb(w);
      @(posedge clk_4f); #1;
      if (exp_q.size() != 0) exp_out = {1'b1, exp_q.pop_front()};
      else exp_out = {2'b00, 8'h00};
      n_total++;
      if ({bus.valid_mux_32_8, bus.sop_mux_32_8, bus.data_mux_32_8} !== exp_out)
        $display("FAIL stall_out: cycle %0d got %b_%b_%h want %b_%b_%h", c, bus.valid_mux_32_8,
                 bus.sop_mux_32_8, bus.data_mux_32_8, exp_out[9], exp_out[8], exp_out[7:0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_word;
    logic [31:0] words [2];
    logic [9:0]  exp_out;
    logic        v;
    words[0] = 32'hA1B2C3D4; words[1] = 32'hDEADBEEF;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, words[c]);
      if (bus.ready_out_32) push_msb(words[c]);
      @(posedge clk_4f); #1;
      exp_out = {1'b1, exp_q.pop_front()};
      n_total++;
      if ({bus.valid_mux_32_8, bus.sop_mux_32_8, bus.data_mux_32_8} !== exp_out)
        $display("FAIL midrst_pre: cycle %0d got %b_%b_%h want %b_%b_%h", c, bus.valid_mux_32_8,
                 bus.sop_mux_32_8, bus.data_mux_32_8, exp_out[9], exp_out[8], exp_out[7:0]);
      else n_pass++;
    end
    n_total++;
    if (dbg.hold_full !== 1'b1) $display("FAIL midrst_held: hold_full got %b want 1", dbg.hold_full);
    else n_pass++;
    #2;
    reset = 1'b1;
    bus.valid_in_32 = 1'b0;
    #1;
    exp_q.delete();
    n_total++;
    if ({bus.valid_mux_32_8, bus.sop_mux_32_8, bus.data_mux_32_8, bus.ready_out_32} !== {2'b00, 8'h00, 1'b1} || dbg !== '0)
      $display("FAIL midrst_async: got v=%b s=%b d=%h r=%b dbg=%h want 0 0 00 1 0",
               bus.valid_mux_32_8, bus.sop_mux_32_8, bus.data_mux_32_8, bus.ready_out_32, dbg);
    else n_pass++;
    @(negedge clk_4f);
    reset = 1'b0;
    for (int c = 0; c < 7; c++) begin
      v = (c == 0);
      drive(v, v ? 32'h11223344 : 32'h0);
      n_total++;
      if (bus.ready_out_32 !== (exp_q.size() < 4)) $display("FAIL midrst_ready: cycle %0d got %b", c, bus.ready_out_32);
      else n_pass++;
      if (v && bus.ready_out_32) push_msb(32'h11223344);
      @(posedge clk_4f); #1;
      if (exp_q.size() != 0) exp_out = {1'b1, exp_q.pop_front()};
      else exp_out = {2'b00, 8'h00};
      n_total++;
      if ({bus.valid_mux_32_8, bus.sop_mux_32_8, bus.data_mux_32_8} !== exp_out)
        $display("FAIL midrst_post: cycle %0d got %b_%b_%h want %b_%b_%h", c, bus.valid_mux_32_8,
                 bus.sop_mux_32_8, bus.data_mux_32_8, exp_out[9], exp_out[8], exp_out[7:0]);
      else n_pass++;
    end
  endtask

  task automatic test_lsb_first;
    logic [9:0]  exp_out;
    logic [31:0] w;
    logic        v;
    w = 32'hA1B2C3D4;
    for (int c = 0; c < 7; c++) begin
      v = (c == 0);
      drive_lsb(v, v ? w : 32'h0);
      n_total++;
      if (bus_lsb.ready_out_32 !== (exp_q.size() < 4)) $display("FAIL lsb_ready: cycle %0d got %b", c, bus_lsb.ready_out_32);
      else n_pass++;
      if (v && bus_lsb.ready_out_32)
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), w[8*i +: 8]});
      @(posedge clk_4f); #1;
      if (exp_q.size() != 0) exp_out = {1'b1, exp_q.pop_front()};
      else exp_out = {2'b00, 8'h00};
      n_total++;
      if ({bus_lsb.valid_mux_32_8, bus_lsb.sop_mux_32_8, bus_lsb.data_mux_32_8} !== exp_out)
        $display("FAIL lsb_out: cycle %0d got %b_%b_%h want %b_%b_%h", c, bus_lsb.valid_mux_32_8,
                 bus_lsb.sop_mux_32_8, bus_lsb.data_mux_32_8, exp_out[9], exp_out[8], exp_out[7:0]);
      else n_pass++;
    end
    n_total++;
    if (dbg_lsb.cnt !== 2'd0) $display("FAIL lsb_end_cnt: got %0d want 0", dbg_lsb.cnt);
    else n_pass++;
  endtask

  // Reference 8->32 reassembly of the MSB-first stream.
  task automatic test_loopback;
    logic [31:0] words [4];
    logic [31:0] asm_w;
    logic [31:0] exp_w;
    int          nbytes = 0;
    int          idx = 0;
    int          words_out = 0;
    words[0] = 32'hA1B2C3D4;
    for (int i = 1; i < 4; i++) words[i] = $urandom;
    asm_w = '0;
    for (int c = 0; c < 40 && words_out < 4; c++) begin
      drive(idx < 4, (idx < 4) ? words[idx] : 32'h0);
      if (idx < 4 && bus.ready_out_32) begin
        word_q.push_back(words[idx]);
        idx++;
      end
      @(posedge clk_4f); #1;
      if (bus.valid_mux_32_8) begin
        if (bus.sop_mux_32_8) nbytes = 0;
        asm_w = {asm_w[23:0], bus.data_mux_32_8};
        nbytes++;
        if (nbytes == 4) begin
          exp_w = (word_q.size() != 0) ? word_q.pop_front() : 32'hxxxxxxxx;
          n_total++;
          if (asm_w !== exp_w) $display("FAIL loopback_word: word %0d got %h want %h", words_out, asm_w, exp_w);
          else n_pass++;
          words_out++;
          nbytes = 0;
        end
      end
    end
    drive(1'b0, 32'h0);
    n_total++;
    if (words_out != 4 || word_q.size() != 0) $display("FAIL loopback_count: got %0d words want 4", words_out);
    else n_pass++;
  endtask

  initial begin
    bus.valid_in_32     = 1'b0;
    bus.data_in_32      = '0;
    bus_lsb.valid_in_32 = 1'b0;
    bus_lsb.data_in_32  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_source_stall();
    test_reset_mid_word();
    test_lsb_first();
    test_loopback();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
